wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the register file. Merges two result producers onto
//  the regfile's single write port (regwr/rw/busw): the ALU result path and the load-data path.
//  - Valid/ready handshake per source; round-robin arbitration; one write per cycle.
//  - x0 suppression.
//  - Registered write outputs.
// PARAMETERS
//  XLEN     32  data width of results and busw
//  REG_AW    5  register index width (32 architectural registers)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      reset, synchronous, active-low (one clock; reset is synchronous and active-low)
//  wb_stall   in   1      hazard-unit freeze; no grants while high
//  alu_valid  in   1      ALU result offered
//  alu_ready  out  1      ALU result accepted this cycle
//  alu_rd     in   REG_AW ALU destination register
//  alu_data   in   XLEN   ALU result
//  ld_valid   in   1      load result offered
//  ld_ready   out  1      load result accepted this cycle
//  ld_rd      in   REG_AW load destination register
//  ld_data    in   XLEN   load data
//  regwr      out  1      regfile write enable (registered)
//  rw         out  REG_AW regfile write index (registered)
//  busw       out  XLEN   regfile write data (registered)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): regwr=0, rw=0, busw=0, rr_ptr=PRI_LD; ready outputs are 0 while rst==0.
//  - Handshake: transfer when valid&&ready. Ready is combinational:
//    - depends only on both valids, wb_stall, rr_ptr and rst;
//    - never depends on ready.
//    - Sources hold rd/data stable while valid && !ready.
//  - Arbitration:
//    - Only one valid: that source is granted.
//    - Both valid: source named by rr_ptr is granted; rr_ptr then flips to the other source.
//    - Single-source grant: rr_ptr flips to the other source.
//    - No grant: rr_ptr holds.
//  - wb_stall==1: alu_ready=ld_ready=0, regwr<=0, rr_ptr holds; rw/busw hold.
//  - Latency: granted result appears on regwr/rw/busw the next cycle; one cycle only.
//  - No grant: regwr<=0 next cycle; rw/busw hold their last value.
//  - x0: a granted transfer with rd==0 completes its handshake, but regwr<=0 next cycle. rw/busw still load.
//  - Throughput: one write per cycle. A continuously valid source is starved at most one cycle.
//  - Reset mid-transfer: offered results are dropped (no ready). regwr is forced 0 the following cycle.
// CONFIGURATION
//  WB_BYPASS_EN
//    - Defined: adds ports ra, rb (in REG_AW); busa_in, busb_in (in XLEN); busa_out, busb_out (out XLEN).
//    - busa_out = (regwr && rw==ra && ra!=0) ? busw : busa_in; busb_out likewise with rb.
//    - Purely combinational on the registered write; covers the regfile's write-to-read window.
//    - Not defined: those ports do not exist; no other behaviour changes.
// STRUCTURE
//  - wb_pkg holds:
//    - localparams PRI_ALU=1'b0, PRI_LD=1'b1;
//    - XLEN and REG_AW defaults;
//    - localparam REG_X0={REG_AW{1'b0}}.
//  - One sub-module, rr_arb2: 2-requester round-robin arbiter.
//    - Inputs: req[1:0], stall.
//    - Outputs: gnt[1:0] (one-hot or zero).
//    - Owns rr_ptr; same clk/rst.
//  - Top level holds the source mux, x0 suppression, output registers and the optional bypass.
// TESTING
//  1 Reset: hold rst=0 3 cycles with both valids high -> readies 0, regwr=0, rw=0, busw=0.
//  2 Single source:
//    - Stimulus: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF for 1 cycle.
//    - Response: alu_ready=1 that cycle; next cycle regwr=1, rw=5, busw=32'hDEADBEEF; following cycle regwr=0.
//  3 Contention:
//    - Stimulus: both valid for 4 cycles; ld rd=1..4, alu rd=9..12, advancing on handshake.
//    - Response: grants LD,ALU,LD,ALU; rw sequence 1,9,2,10 one cycle later.
//  4 x0:
//    - Stimulus: ld_valid=1, ld_rd=0, ld_data=32'h1234.
//    - Response: ld_ready=1; next cycle regwr=0, rw=0, busw=32'h1234.
//  5 Stall:
//    - Stimulus: wb_stall=1 for 2 cycles with alu_valid=1, rd=7.
//    - Response: alu_ready=0, regwr=0. On release, granted next cycle; regwr=1, rw=7 one cycle later.
//  6 WB_BYPASS_EN:
//    - Stimulus: regwr=1, rw=3, busw=32'hA5A5A5A5; ra=3, rb=0, busa_in=busb_in=0.
//    - Response: busa_out=32'hA5A5A5A5, busb_out=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter: source priority encodings, default widths, x0 index.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic PRI_ALU = 1'b0;
  localparam logic PRI_LD  = 1'b1;

  localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is the ALU, bit 1 the load path.
module rr_arb2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       stall,
  output logic [1:0] gnt
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt      = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (rst && !stall) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (rr_ptr_q == PRI_LD) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      // Any grant hands priority to the source that did not just win.
      if (gnt != 2'b00) rr_ptr_d = gnt[0] ? PRI_LD : PRI_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_ptr_q <= PRI_LD;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single regfile write port.
// Optional WB_BYPASS_EN adds a write-to-read forwarding path on two read buses.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN   = wb_pkg::XLEN,
  parameter int REG_AW = wb_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_stall,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              regwr,
  output logic [REG_AW-1:0] rw,
  output logic [XLEN-1:0]   busw
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [XLEN-1:0]   busa_in,
  input  logic [XLEN-1:0]   busb_in,
  output logic [XLEN-1:0]   busa_out,
  output logic [XLEN-1:0]   busb_out
`endif
);

  logic [1:0]        gnt;
  logic              regwr_q, regwr_d;
  logic [REG_AW-1:0] rw_q, rw_d;
  logic [XLEN-1:0]   busw_q, busw_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({ld_valid, alu_valid}),
    .stall (wb_stall),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[0];
  assign ld_ready  = gnt[1];

  always_comb begin
    regwr_d = 1'b0;
    rw_d    = rw_q;
    busw_d  = busw_q;
    if (gnt[1]) begin
      rw_d    = ld_rd;
      busw_d  = ld_data;
      regwr_d = (ld_rd != REG_AW'(REG_X0));
    end else if (gnt[0]) begin
      rw_d    = alu_rd;
      busw_d  = alu_data;
      regwr_d = (alu_rd != REG_AW'(REG_X0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else begin
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
    end
  end

  assign regwr = regwr_q;
  assign rw    = rw_q;
  assign busw  = busw_q;

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to readers of the same register; x0 is never forwarded.
  assign busa_out = (regwr_q && rw_q == ra && ra != REG_AW'(REG_X0)) ? busw_q : busa_in;
  assign busb_out = (regwr_q && rw_q == rb && rb != REG_AW'(REG_X0)) ? busw_q : busb_in;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        regwr;
  logic [4:0]  rw;
  logic [31:0] busw;
`ifdef WB_BYPASS_EN
  logic [4:0]  ra, rb;
  logic [31:0] busa_in, busb_in, busa_out, busb_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_stall  (wb_stall),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .regwr     (regwr),
    .rw        (rw),
    .busw      (busw)
`ifdef WB_BYPASS_EN
    ,
    .ra        (ra),
    .rb        (rb),
    .busa_in   (busa_in),
    .busb_in   (busb_in),
    .busa_out  (busa_out),
    .busb_out  (busb_out)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who won last decides the next contended grant; outputs are last cycle's winner.
  bit          m_known = 1'b0;
  bit          m_last_ld = 1'b0;
  logic        m_regwr;
  logic [4:0]  m_rw;
  logic [31:0] m_busw;

  always @(negedge clk) begin
    bit ea, el;
    ea = 1'b0;
    el = 1'b0;
    if (rst && !wb_stall) begin
      if (alu_valid && ld_valid) begin
        el = !m_last_ld;
        ea = m_last_ld;
      end else begin
        ea = alu_valid;
        el = ld_valid;
      end
    end
    check("model_alu_ready", 32'(alu_ready), 32'(ea));
    check("model_ld_ready",  32'(ld_ready),  32'(el));
    if (m_known) begin
      check("model_regwr", 32'(regwr), 32'(m_regwr));
      check("model_rw",    32'(rw),    32'(m_rw));
      check("model_busw",  busw,       m_busw);
    end
    if (!rst) begin
      m_known   = 1'b1;
      m_last_ld = 1'b0;
      m_regwr   = 1'b0;
      m_rw      = '0;
      m_busw    = '0;
    end else if (el) begin
      m_last_ld = 1'b1;
      m_regwr   = (ld_rd != 0);
      m_rw      = ld_rd;
      m_busw    = ld_data;
    end else if (ea) begin
      m_last_ld = 1'b0;
      m_regwr   = (alu_rd != 0);
      m_rw      = alu_rd;
      m_busw    = alu_data;
    end else begin
      m_regwr   = 1'b0;
    end
  end

  logic gl[4], ga[4];
  logic [4:0] rws[4];
  int exp_rw[4] = '{1, 9, 2, 10};
  bit ap, lp;
  int li, ai;

  initial begin
    rst = 1'b0; wb_stall = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1111;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h2222;
`ifdef WB_BYPASS_EN
    ra = '0; rb = '0; busa_in = '0; busb_in = '0;
`endif

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_alu_ready", 32'(alu_ready), 0);
      check("rst_ld_ready",  32'(ld_ready),  0);
    end
    check("rst_regwr", 32'(regwr), 0);
    check("rst_rw",    32'(rw),    0);
    check("rst_busw",  busw,       0);
    tick();

    rst = 1'b1;
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    check("single_alu_ready", 32'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("single_regwr", 32'(regwr), 1);
    check("single_rw",    32'(rw),    5);
    check("single_busw",  busw,       32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("single_regwr_drop", 32'(regwr), 0);
    tick();

    li = 1; ai = 9;
    ld_valid = 1'b1; ld_rd = 5'(li); ld_data = 32'hAAAA0000;
    alu_valid = 1'b1; alu_rd = 5'(ai); alu_data = 32'hBBBB0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) rws[k-1] = rw;
      if (k < 4) begin
        gl[k] = ld_ready;
        ga[k] = alu_ready;
      end
      tick();
      if (k < 4) begin
        if (gl[k]) begin li++; ld_rd = 5'(li); end
        if (ga[k]) begin ai++; alu_rd = 5'(ai); end
      end
      if (k == 3) begin
        ld_valid = 1'b0;
        alu_valid = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("contend_ld_gnt%0d", k),  32'(gl[k]), 32'((k % 2) == 0));
      check($sformatf("contend_alu_gnt%0d", k), 32'(ga[k]), 32'((k % 2) == 1));
      check($sformatf("contend_rw%0d", k),      32'(rws[k]), 32'(exp_rw[k]));
    end

    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234;
    @(negedge clk);
    check("x0_ld_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 1'b0;
    @(negedge clk);
    check("x0_regwr", 32'(regwr), 0);
    check("x0_rw",    32'(rw),    0);
    check("x0_busw",  busw,       32'h1234);
    tick();

    wb_stall = 1'b1; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_alu_ready", 32'(alu_ready), 0);
      check("stall_regwr",     32'(regwr),     0);
      tick();
    end
    wb_stall = 1'b0;
    @(negedge clk);
    check("unstall_alu_ready", 32'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("unstall_regwr", 32'(regwr), 1);
    check("unstall_rw",    32'(rw),    7);
    tick();

`ifdef WB_BYPASS_EN
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5A5A5;
    tick();
    alu_valid = 1'b0;
    ra = 5'd3; rb = 5'd0; busa_in = '0; busb_in = '0;
    @(negedge clk);
    check("byp_busa", busa_out, 32'hA5A5A5A5);
    check("byp_busb", busb_out, 32'h0);
    tick();
    busa_in = 32'h55;
    @(negedge clk);
    check("byp_busa_idle", busa_out, 32'h55);
    tick();
`endif

    ap = 1'b0; lp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) != 0);
      wb_stall = ($urandom_range(0, 7) == 0);
      if (!ap) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!lp) begin
        ld_valid = ($urandom_range(0, 3) != 0);
        ld_rd    = 5'($urandom_range(0, 31));
        ld_data  = $urandom;
      end
      @(negedge clk);
      ap = alu_valid && !alu_ready;
      lp = ld_valid && !ld_ready;
      tick();
    end
    rst = 1'b1; wb_stall = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
